// File: rtl/adj_matrix_cache_pkg.sv
// adj_matrix_cache_pkg: shared FSM encoding, default sizes and address-split helpers for adj_matrix_cache
`ifndef MAX_VERTSBITS
`define MAX_VERTSBITS 8
`endif
`ifndef CACHE_HIT_LATENCY
`define CACHE_HIT_LATENCY 3
`endif
package adj_matrix_cache_pkg;
  localparam int DEF_VB = `MAX_VERTSBITS;
  localparam int DEF_LINE_BITS = 64;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_HIT_LATENCY = `CACHE_HIT_LATENCY;
  localparam int REQ_HIT_LATENCY = 3;
  typedef enum logic [2:0] {RUN, MISS_REQ, MISS_WAIT, REFILL, REPLAY, FLUSH} state_t;
  function automatic int la_bits(input int vb, input int line_bits);
    return 2 * vb - $clog2(line_bits);
  endfunction
endpackage

// File: rtl/adj_cache_mem.sv
// adj_cache_mem: tag+data dual-port RAM, registered read frozen by the pipeline clock enable
module adj_cache_mem
  import adj_matrix_cache_pkg::*;
#(
  parameter int TW = 4,
  parameter int IB = 6,
  parameter int LB = 64
) (
  input  logic          i_clk,
  input  logic          ce,
  input  logic [IB-1:0] raddr,
  output logic [TW-1:0] rtag,
  output logic [LB-1:0] rdata,
  input  logic          we,
  input  logic [IB-1:0] waddr,
  input  logic [TW-1:0] wtag,
  input  logic [LB-1:0] wdata
);
  logic [TW+LB-1:0] ram [2**IB];
  // refill installs tag and line in one write
  always_ff @(posedge i_clk)
    if (we) ram[waddr] <= {wtag, wdata};
  // registered read; output holds while the pipeline is frozen
  always_ff @(posedge i_clk)
    if (ce) {rtag, rdata} <= ram[raddr];
endmodule

// File: rtl/adj_matrix_cache.sv
// adj_matrix_cache: direct-mapped adjacency-bit read cache, 3-cycle hit, stall-refill-replay on miss; ADJ_CACHE_STATS_EN enables hit/miss counters
module adj_matrix_cache
  import adj_matrix_cache_pkg::*;
#(
  parameter int VB = DEF_VB,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int HIT_LATENCY = DEF_HIT_LATENCY,
  localparam int OB = $clog2(LINE_BITS),
  localparam int LA = la_bits(VB, LINE_BITS),
  localparam int TW = LA - INDEX_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_req,
  input  logic [VB-1:0]        i_i,
  input  logic [VB-1:0]        i_j,
  input  logic                 i_squash,
  output logic                 o_valid,
  output logic                 o_isconn,
  output logic                 o_stalled,
  input  logic                 i_flush,
  output logic                 o_mem_req,
  output logic [LA-1:0]        o_mem_addr,
  input  logic                 i_mem_ack,
  input  logic                 i_mem_rvalid,
  input  logic [LINE_BITS-1:0] i_mem_rdata,
  output logic [31:0]          o_hits,
  output logic [31:0]          o_misses
);
  if (HIT_LATENCY != REQ_HIT_LATENCY) begin : g_lat_chk
    $error("adj_matrix_cache: HIT_LATENCY must be 3");
  end
  state_t state;
  logic a_v, b_v, c_v, fl_p, run, rep, c_hit, miss, en, ftake;
  logic [LA-1:0] a_la, b_la, c_la;
  logic [OB-1:0] a_off, b_off, c_off;
  logic [INDEX_BITS-1:0] c_idx, fcnt;
  logic [2**INDEX_BITS-1:0] vbits;
  logic [LINE_BITS-1:0] line_q, rdata;
  logic [TW-1:0] rtag;
  assign run = state == RUN;
  assign rep = state == REPLAY;
  assign c_idx = c_la[INDEX_BITS-1:0];
  assign c_hit = c_v & vbits[c_idx] & (rtag == c_la[LA-1:INDEX_BITS]);
  assign miss = run & c_v & ~c_hit & ~i_squash;
  assign o_stalled = ~run | miss;
  assign en = ~o_stalled;
  assign o_valid = run & c_hit & ~i_squash;
  assign o_isconn = o_valid & rdata[c_off];
  assign ftake = en & (fl_p | i_flush);
  assign o_mem_addr = c_la;
  adj_cache_mem #(.TW(TW), .IB(INDEX_BITS), .LB(LINE_BITS)) u_mem (
    .i_clk(i_clk),
    .ce(en | rep),
    .raddr(rep ? c_idx : b_la[INDEX_BITS-1:0]),
    .rtag(rtag),
    .rdata(rdata),
    .we(state == REFILL),
    .waddr(c_idx),
    .wtag(c_la[LA-1:INDEX_BITS]),
    .wdata(line_q)
  );
  // stage valids: advance when enabled, killed by squash or an accepted flush
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      a_v <= 1'b0;
      b_v <= 1'b0;
      c_v <= 1'b0;
    end else begin
      a_v <= ~i_squash & ~ftake & (en ? i_req : a_v);
      b_v <= ~i_squash & ~ftake & (en ? a_v : b_v);
      c_v <= ~i_squash & ~ftake & (en ? b_v : c_v);
    end
  // query payload, qualified by the stage valids so it needs no reset
  always_ff @(posedge i_clk)
    if (en) begin
      a_la <= {i_i, i_j[VB-1:OB]};
      a_off <= i_j[OB-1:0];
      b_la <= a_la;
      b_off <= a_off;
      c_la <= b_la;
      c_off <= b_off;
    end
  // miss/refill/replay/flush controller with line valid bits
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= RUN;
      o_mem_req <= 1'b0;
      fl_p <= 1'b0;
      fcnt <= '0;
      vbits <= '0;
      line_q <= '0;
    end else begin
      fl_p <= (fl_p | i_flush) & ~ftake;
      case (state)
        RUN: begin
          if (miss) begin
            state <= MISS_REQ;
            o_mem_req <= 1'b1;
          end
          if (ftake) state <= FLUSH;
        end
        MISS_REQ: if (i_mem_ack) begin
          state <= MISS_WAIT;
          o_mem_req <= 1'b0;
        end
        MISS_WAIT: if (i_mem_rvalid) begin
          state <= REFILL;
          line_q <= i_mem_rdata;
        end
        REFILL: begin
          vbits[c_idx] <= 1'b1;
          state <= (c_v & ~i_squash) ? REPLAY : RUN;
        end
        REPLAY: state <= RUN;
        FLUSH: begin
          vbits[fcnt] <= 1'b0;
          fcnt <= fcnt + 1'b1;
          if (&fcnt) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
`ifdef ADJ_CACHE_STATS_EN
  logic rp;
  // saturating counters; the response right after a replay counts only as a miss
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      rp <= 1'b0;
      o_hits <= '0;
      o_misses <= '0;
    end else begin
      rp <= rep;
      if (ftake) begin
        o_hits <= '0;
        o_misses <= '0;
      end else begin
        if (o_valid & ~rp & ~&o_hits) o_hits <= o_hits + 32'd1;
        if (miss & ~&o_misses) o_misses <= o_misses + 32'd1;
      end
    end
`else
  assign o_hits = '0;
  assign o_misses = '0;
`endif
endmodule
